// File: rtl/branch_target_buffer.sv
// -----------------------------------------------------------------------------
// branch_target_buffer
//
// Two-way set-associative branch target buffer for the LC-3b fetch stage.
// The IF stage looks a fetch PC up combinationally. The WB stage feeds back
// each resolved control-flow instruction, which allocates, refreshes or
// retires an entry.
//
// Address split (IDX_W = log2(NUM_SETS)):
//   index = pc[IDX_W:1]   tag = pc[15:IDX_W+1]   pc[0] is ignored
//
// Parameters
//   NUM_SETS  number of sets (power of two, >= 2)
//   NUM_WAYS  associativity, must be 2
//
// Ports
//   clk               rising-edge clock
//   rst_n             synchronous active-low reset (clears valid + LRU only)
//   lookup_en         IF-stage lookup qualifier
//   lookup_pc         IF-stage fetch PC
//   if_btb_hit        lookup hit (gated by lookup_en and rst_n)
//   if_btb_target     predicted target on hit, 16'h0000 otherwise
//   update_valid      one resolved control-flow instruction this cycle
//   resolved_pc       PC of the resolved instruction
//   resolved_target   computed target address
//   wb_take_jump      resolved direction, 1 = taken
//   update_is_uncond  resolved instruction is JMP/JSR/TRAP
// -----------------------------------------------------------------------------
module branch_target_buffer #(
  parameter int NUM_SETS = 8,
  parameter int NUM_WAYS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lookup_en,
  input  logic [15:0] lookup_pc,
  output logic        if_btb_hit,
  output logic [15:0] if_btb_target,
  input  logic        update_valid,
  input  logic [15:0] resolved_pc,
  input  logic [15:0] resolved_target,
  input  logic        wb_take_jump,
  input  logic        update_is_uncond
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 15 - IDX_W;

  // Elaboration-time guard on the supported configuration.
  if (NUM_WAYS != 2) begin : g_bad_ways
    $error("branch_target_buffer: NUM_WAYS must be 2");
  end
  if (NUM_SETS < 2 || (1 << IDX_W) != NUM_SETS) begin : g_bad_sets
    $error("branch_target_buffer: NUM_SETS must be a power of two >= 2");
  end

  // Storage. Valid and LRU are control state and take the reset; tags and
  // targets are plain data and are only ever written on allocation/refresh.
  logic              valid_q  [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]  tag_q    [NUM_SETS][NUM_WAYS];
  logic [15:0]       target_q [NUM_SETS][NUM_WAYS];
  logic              lru_q    [NUM_SETS];   // names the victim way

  // Allocation victim: first invalid way, else the LRU way.
  function automatic logic pick_alloc_way(input logic v0, input logic v1,
                                          input logic lru);
    if (!v0)      return 1'b0;
    else if (!v1) return 1'b1;
    else          return lru;
  endfunction

  // ---------------------------------------------------------------------------
  // Lookup (combinational, reads pre-edge state, no update bypass)
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [15:0]      lk_tgt;

  assign lk_idx = lookup_pc[IDX_W:1];
  assign lk_tag = lookup_pc[15:IDX_W+1];

  always_comb begin
    lk_hit = 1'b0;
    lk_tgt = 16'h0000;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
        lk_hit = 1'b1;
        lk_tgt = target_q[lk_idx][w];
      end
    end
  end

  assign if_btb_hit    = lookup_en & rst_n & lk_hit;
  assign if_btb_target = if_btb_hit ? lk_tgt : 16'h0000;

  // ---------------------------------------------------------------------------
  // Update decode
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             up_way;
  logic             alloc_way;
  logic             wr_way;
  logic             up_fire;

  assign up_idx  = resolved_pc[IDX_W:1];
  assign up_tag  = resolved_pc[15:IDX_W+1];
  assign up_fire = rst_n & update_valid;

  always_comb begin
    up_hit = 1'b0;
    up_way = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag)) begin
        up_hit = 1'b1;
        up_way = w[0];
      end
    end
  end

  assign alloc_way = pick_alloc_way(valid_q[up_idx][0], valid_q[up_idx][1],
                                    lru_q[up_idx]);
  assign wr_way    = up_hit ? up_way : alloc_way;

  // ---------------------------------------------------------------------------
  // Control state: valid bits and LRU
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        lru_q[s] <= 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
        end
      end
    end else if (update_valid) begin
      if (wb_take_jump) begin
        // Taken: refresh the hit way or allocate; either way the written
        // way becomes most recently used.
        valid_q[up_idx][wr_way] <= 1'b1;
        lru_q[up_idx]           <= ~wr_way;
      end else if (up_hit && !update_is_uncond) begin
        // Not-taken conditional branch: retire the entry and make its
        // now-empty slot the preferred victim.
        valid_q[up_idx][up_way] <= 1'b0;
        lru_q[up_idx]           <= up_way;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Data state: tags and targets (never reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (up_fire && wb_take_jump) begin
      target_q[up_idx][wr_way] <= resolved_target;
      if (!up_hit) begin
        tag_q[up_idx][wr_way] <= up_tag;
      end
    end
  end

  // Bit 0 of both PCs is deliberately outside the index/tag split.
  logic unused_pc_lsb;
  assign unused_pc_lsb = lookup_pc[0] ^ resolved_pc[0];

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;

  localparam int NS = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lookup_en;
  logic [15:0] lookup_pc;
  logic        if_btb_hit;
  logic [15:0] if_btb_target;
  logic        update_valid;
  logic [15:0] resolved_pc;
  logic [15:0] resolved_target;
  logic        wb_take_jump;
  logic        update_is_uncond;

  int total = 0;
  int bad   = 0;
  logic chk_on = 1'b0;

  branch_target_buffer #(.NUM_SETS(NS), .NUM_WAYS(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .lookup_en        (lookup_en),
    .lookup_pc        (lookup_pc),
    .if_btb_hit       (if_btb_hit),
    .if_btb_target    (if_btb_target),
    .update_valid     (update_valid),
    .resolved_pc      (resolved_pc),
    .resolved_target  (resolved_target),
    .wb_take_jump     (wb_take_jump),
    .update_is_uncond (update_is_uncond)
  );

  always #5 clk = ~clk;

  // Reference model: each set is a recency-ordered list of at most two
  // entries keyed by pc[15:1]; slot 0 is least recently used.
  logic [14:0] mkey [NS][2];
  logic [15:0] mtgt [NS][2];
  int          mn   [NS];

  initial for (int s = 0; s < NS; s++) mn[s] = 0;

  function automatic int set_of(input logic [15:0] pc);
    return int'(pc[15:1]) % NS;
  endfunction

  function automatic void mlook(input logic en, input logic rn,
                                input logic [15:0] pc,
                                output logic h, output logic [15:0] t);
    int s;
    s = set_of(pc);
    h = 1'b0;
    t = 16'h0000;
    if (en && rn) begin
      for (int i = 0; i < mn[s]; i++) begin
        if (mkey[s][i] == pc[15:1]) begin
          h = 1'b1;
          t = mtgt[s][i];
        end
      end
    end
  endfunction

  function automatic void mremove(input int s, input int f);
    for (int j = f; j < mn[s] - 1; j++) begin
      mkey[s][j] = mkey[s][j+1];
      mtgt[s][j] = mtgt[s][j+1];
    end
    mn[s] = mn[s] - 1;
  endfunction

  function automatic void mappend(input int s, input logic [14:0] k,
                                  input logic [15:0] t);
    mkey[s][mn[s]] = k;
    mtgt[s][mn[s]] = t;
    mn[s] = mn[s] + 1;
  endfunction

  always @(posedge clk) begin : model_update
    int s;
    int f;
    if (!rst_n) begin
      for (int i = 0; i < NS; i++) mn[i] = 0;
    end else if (update_valid) begin
      s = set_of(resolved_pc);
      f = -1;
      for (int i = 0; i < mn[s]; i++)
        if (mkey[s][i] == resolved_pc[15:1]) f = i;
      if (wb_take_jump) begin
        if (f >= 0) mremove(s, f);
        else if (mn[s] == 2) mremove(s, 0);
        mappend(s, resolved_pc[15:1], resolved_target);
      end else if (!update_is_uncond && f >= 0) begin
        mremove(s, f);
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin : compare
    logic        mh;
    logic [15:0] mt;
    if (chk_on) begin
      mlook(lookup_en, rst_n, lookup_pc, mh, mt);
      total++;
      if (if_btb_hit !== mh || if_btb_target !== mt) begin
        bad++;
        $display("FAIL cmp pc=%h dut hit=%0b tgt=%h model hit=%0b tgt=%h",
                 lookup_pc, if_btb_hit, if_btb_target, mh, mt);
      end
    end
  end

  task automatic cyc(input logic rn, input logic en, input logic [15:0] lpc,
                     input logic uv, input logic [15:0] rpc,
                     input logic [15:0] rt, input logic tk, input logic unc);
    @(posedge clk);
    #2;
    rst_n            = rn;
    lookup_en        = en;
    lookup_pc        = lpc;
    update_valid     = uv;
    resolved_pc      = rpc;
    resolved_target  = rt;
    wb_take_jump     = tk;
    update_is_uncond = unc;
  endtask

  task automatic look(input logic [15:0] pc);
    cyc(1'b1, 1'b1, pc, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic upd(input logic [15:0] lpc, input logic [15:0] rpc,
                     input logic [15:0] rt, input logic tk, input logic unc);
    cyc(1'b1, 1'b1, lpc, 1'b1, rpc, rt, tk, unc);
  endtask

  // Hand-computed expectation, checked against both the DUT and the model.
  task automatic lit(input string nm, input logic eh, input logic [15:0] et);
    logic        mh;
    logic [15:0] mt;
    #2;
    mlook(lookup_en, rst_n, lookup_pc, mh, mt);
    total++;
    if (if_btb_hit !== eh || if_btb_target !== et) begin
      bad++;
      $display("FAIL %s dut hit=%0b tgt=%h want hit=%0b tgt=%h",
               nm, if_btb_hit, if_btb_target, eh, et);
    end
    total++;
    if (mh !== eh || mt !== et) begin
      bad++;
      $display("FAIL %s model hit=%0b tgt=%h want hit=%0b tgt=%h",
               nm, mh, mt, eh, et);
    end
  endtask

  logic [15:0] pc_tab [8];

  initial begin
    pc_tab[0] = 16'h3006; pc_tab[1] = 16'h4006; pc_tab[2] = 16'h5006;
    pc_tab[3] = 16'h3002; pc_tab[4] = 16'h6006; pc_tab[5] = 16'h300E;
    pc_tab[6] = 16'h3007; pc_tab[7] = 16'h4002;

    rst_n = 1'b0; lookup_en = 1'b0; lookup_pc = 16'h0000;
    update_valid = 1'b0; resolved_pc = 16'h0000; resolved_target = 16'h0000;
    wb_take_jump = 1'b0; update_is_uncond = 1'b0;

    // Reset held: outputs forced quiet.
    cyc(1'b0, 1'b1, 16'h3006, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    lit("rst_hold", 1'b0, 16'h0000);
    cyc(1'b0, 1'b1, 16'h3006, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk_on = 1'b1;

    // Cold lookup, then allocate and hit.
    look(16'h3000);                                 lit("cold", 1'b0, 16'h0000);
    upd(16'h3000, 16'h3006, 16'h3020, 1'b1, 1'b0);  lit("alloc_cyc", 1'b0, 16'h0000);
    look(16'h3006);                                 lit("alloc_hit", 1'b1, 16'h3020);
    look(16'h4006);                                 lit("diff_tag", 1'b0, 16'h0000);

    // Eviction in set 3.
    upd(16'h4006, 16'h4006, 16'h4040, 1'b1, 1'b0);  lit("pre_alloc", 1'b0, 16'h0000);
    upd(16'h4006, 16'h5006, 16'h5050, 1'b1, 1'b0);  lit("fill2", 1'b1, 16'h4040);
    look(16'h3006);                                 lit("evicted", 1'b0, 16'h0000);
    look(16'h4006);                                 lit("keep_4006", 1'b1, 16'h4040);
    look(16'h5006);                                 lit("keep_5006", 1'b1, 16'h5050);

    // Re-allocate 3006 (LRU is 4006 now).
    upd(16'h3006, 16'h3006, 16'h3030, 1'b1, 1'b0);  lit("realloc_cyc", 1'b0, 16'h0000);
    look(16'h3006);                                 lit("realloc", 1'b1, 16'h3030);
    look(16'h4006);                                 lit("lru_victim", 1'b0, 16'h0000);

    // Not-taken: unconditional keeps, conditional invalidates.
    upd(16'h3006, 16'h3006, 16'h0000, 1'b0, 1'b1);  lit("unc_cyc", 1'b1, 16'h3030);
    look(16'h3006);                                 lit("unc_keep", 1'b1, 16'h3030);
    upd(16'h3006, 16'h3006, 16'h0000, 1'b0, 1'b0);  lit("nt_cyc", 1'b1, 16'h3030);
    look(16'h3006);                                 lit("nt_inval", 1'b0, 16'h0000);
    upd(16'h7006, 16'h7006, 16'h7070, 1'b0, 1'b0);
    look(16'h7006);                                 lit("nt_miss", 1'b0, 16'h0000);

    // Same-cycle collision.
    upd(16'h3006, 16'h3006, 16'h3020, 1'b1, 1'b0);
    upd(16'h3006, 16'h3006, 16'h3100, 1'b1, 1'b0);  lit("collide_old", 1'b1, 16'h3020);
    look(16'h3006);                                 lit("collide_new", 1'b1, 16'h3100);
    look(16'h3007);                                 lit("pc0_ignored", 1'b1, 16'h3100);
    cyc(1'b1, 1'b0, 16'h3006, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    lit("en_low", 1'b0, 16'h0000);

    // Independent set.
    upd(16'h3002, 16'h3002, 16'h1234, 1'b1, 1'b0);
    look(16'h3002);                                 lit("set1", 1'b1, 16'h1234);
    look(16'h3006);                                 lit("indep", 1'b1, 16'h3100);

    // Taken hit refreshes LRU: touch 5006, then 6006 must evict 3006.
    upd(16'h5006, 16'h5006, 16'h5055, 1'b1, 1'b0);
    upd(16'h5006, 16'h6006, 16'h6060, 1'b1, 1'b0);  lit("hit_refresh", 1'b1, 16'h5055);
    look(16'h3006);                                 lit("lru_hit_evict", 1'b0, 16'h0000);
    look(16'h6006);                                 lit("new_6006", 1'b1, 16'h6060);

    // Reset mid-stream with a simultaneous update.
    cyc(1'b0, 1'b1, 16'h5006, 1'b1, 16'h7006, 16'h7070, 1'b1, 1'b0);
    lit("rst_mid", 1'b0, 16'h0000);
    look(16'h5006);                                 lit("rst_5006", 1'b0, 16'h0000);
    look(16'h6006);                                 lit("rst_6006", 1'b0, 16'h0000);
    look(16'h3002);                                 lit("rst_3002", 1'b0, 16'h0000);
    look(16'h7006);                                 lit("rst_drop", 1'b0, 16'h0000);

    // Mixed traffic over a small PC pool, checked by the model each cycle.
    for (int i = 0; i < 80; i++) begin
      cyc(1'b1, 1'($urandom_range(0, 3) != 0), pc_tab[$urandom_range(0, 7)],
          1'($urandom_range(0, 1)), pc_tab[$urandom_range(0, 7)],
          16'($urandom), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 3) == 0));
    end
    look(16'h3006);
    @(posedge clk);
    #6;
    chk_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 Parameter: NUM_SETS, default 8, number of sets; power of two, minimum 2.
REQ-002 Parameter: NUM_WAYS, fixed at 2, associativity; no other value is supported.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 lookup_en  input  1  IF-stage lookup qualifier.
REQ-006 lookup_pc  input  16  IF-stage fetch PC (lc3b_word).
REQ-007 if_btb_hit  output  1  lookup hit, consumed by branch_predictor.
REQ-008 if_btb_target  output  16  predicted target on hit, 16'h0000 otherwise.
REQ-009 update_valid  input  1  one resolved control-flow instruction, from WB.
REQ-010 resolved_pc  input  16  PC of the resolved instruction.
REQ-011 resolved_target  input  16  computed target address.
REQ-012 wb_take_jump  input  1  resolved direction: 1 = taken.
REQ-013 update_is_uncond  input  1  resolved instruction is JMP/JSR/TRAP.

Function
REQ-014 Address split: index = pc[log2(NUM_SETS):1]; tag = pc[15:log2(NUM_SETS)+1]; pc[0] is ignored.
REQ-015 Each way of each set holds valid (1), tag, and target (16); each set holds one LRU bit naming the victim way.
REQ-016 Lookup is combinational, with zero-cycle latency.
REQ-017 if_btb_hit = lookup_en & rst_n & (some valid way in the indexed set has a matching tag).
REQ-018 On a hit, if_btb_target is the matching way's target; otherwise it is 16'h0000.
REQ-019 Lookup reads pre-edge state; there is no bypass from an update in the same cycle.
REQ-020 Update write occurs on the rising edge when update_valid=1 and rst_n=1; no write occurs otherwise.
REQ-021 Update taken hit (wb_take_jump=1 and a matching valid way): overwrite that way's target and set LRU to the other way.
REQ-022 Update taken miss: allocate way 0 if invalid, else way 1 if invalid, else the LRU way.
REQ-023 On allocation, write valid=1, tag, and target, and set LRU to the other way.
REQ-024 Update not-taken hit with update_is_uncond=0: clear that way's valid bit; LRU is set to that way.
REQ-025 Update not-taken with update_is_uncond=1: no state change.
REQ-026 Update not-taken miss: no state change.
REQ-027 Two valid ways with the same tag in one set SHALL never arise; the allocation rules guarantee this.
REQ-028 Simultaneous lookup and update to the same set: the lookup returns old contents, and the update is visible next cycle.
REQ-029 Updates to different sets are fully independent; each set's state changes only through its own updates.

Reset
REQ-030 rst_n=0 at a rising edge clears every valid bit and every LRU bit (LRU=0 selects way 0) in that single edge.
REQ-031 Tags and targets are not reset.
REQ-032 While rst_n=0, if_btb_hit=0 and if_btb_target=16'h0000.
REQ-033 An update presented in the same cycle as rst_n=0 is discarded.
REQ-034 Reset asserted mid-stream leaves no valid entry after the edge.
REQ-035 The first cycle after deassertion behaves as an empty table.

Verification
REQ-036 Cold lookup: after reset, lookup_pc=16'h3000, lookup_en=1 -> if_btb_hit=0, if_btb_target=16'h0000.
REQ-037 Allocate/hit: update resolved_pc=16'h3006, resolved_target=16'h3020, taken=1 -> next cycle lookup 16'h3006 gives hit=1, target=16'h3020; lookup 16'h4006 (same set, different tag) gives hit=0.
REQ-038 Eviction: fill set 3 with PCs 16'h3006 and 16'h4006 (in that order), then allocate 16'h5006 -> 16'h3006 is evicted; 16'h4006 and 16'h5006 hit.
REQ-039 Not-taken invalidate: the entry for 16'h3006 exists; update not-taken with uncond=0 -> lookup 16'h3006 misses next cycle; the same sequence with uncond=1 -> it still hits.
REQ-040 Same-cycle collision: lookup 16'h3006 while updating 16'h3006 with a new target 16'h3100 -> the old target is returned that cycle and 16'h3100 the next cycle.
REQ-041 Reset mid-operation: with two valid entries present, pulse rst_n=0 for one cycle together with update_valid=1 -> all lookups miss afterwards, and the update is not stored.
